wait_buffer_replay_ctrl: RTL and testbench
==========================================

// Module: wait_buffer_replay_ctrl
// PURPOSE
// Replays wait_buffer entries parked on a cache-miss block once that block's refill line returns.
// Captures the refilled line, then kicks the wait_buffer search port into walk mode for the block.
// Merges each replayed store into a local line copy, oldest first. Extracts each replayed load's
// result from the merged copy and queues it for writeback. Writes the merged line back to the data cache.
// PARAMETERS
// DATA_WIDTH      32  word width
// ADDR_BITS       32  address width
// BLOCK_ID_START  5   byte-offset bits per line; LINE_BITS = 8<<BLOCK_ID_START (256)
// R_WIDTH         6   destination register tag width
// MICROOP         5   microop width
// ROB_TICKET      3   ROB ticket width
// WB_DEPTH        8   wait_buffer depth; also load-result FIFO depth
// PORTS
// clk                    in   1           clock, rising edge
// rst                    in   1           synchronous active-high reset
// fill_valid/fill_ready  in/out 1/1      refill handshake
// fill_address           in   ADDR_BITS   miss address; block bits used
// fill_line              in   LINE_BITS   refilled line, byte 0 at [7:0]
// wb_search_invalidate   out  1           to wait_buffer search_invalidate
// wb_search_address      out  ADDR_BITS   {fill block, zero offset}
// wb_in_walk_mode        in   1           wait_buffer in_walk_mode
// wb_search_found_one    in   1           wait_buffer search_found_one
// wb_search_found_multi  in   1           wait_buffer search_found_multi
// wb_search_is_store     in   1           entry at peek is a store
// wb_search_address_o    in   ADDR_BITS   entry address
// wb_search_data         in   DATA_WIDTH  entry store data
// wb_search_microop      in   MICROOP     entry microop
// wb_search_dest         in   R_WIDTH     entry destination tag
// wb_search_ticket       in   ROB_TICKET  entry ticket
// line_wr_valid/ready    out/in 1/1      merged line write handshake
// line_wr_address        out  ADDR_BITS   block address, offset bits zero
// line_wr_data           out  LINE_BITS   merged line
// ld_valid/ld_ready      out/in 1/1      load result handshake
// ld_data                out  DATA_WIDTH  extended load result
// ld_dest/ld_ticket      out  R_WIDTH/ROB_TICKET  load tags
// busy                   out  1           state != IDLE
// BEHAVIOUR
// Reset: state=IDLE; load FIFO empty. fill_ready=1, all valids/invalidate=0, busy=0, data outputs=0.
// fill_ready = (state==IDLE) && FIFO empty, so every matching entry fits in the FIFO.
// IDLE: on fill_valid&&fill_ready at cycle T, latch block address and line; state=KICK at T+1.
// KICK: drive wb_search_address.
//  - Wait here while wb_in_walk_mode=1.
//  - If wb_search_found_one=1: pulse wb_search_invalidate for exactly 1 cycle, then go to WALK.
//  - Otherwise go to WRITE; no invalidate.
// WALK, one entry per cycle, consumed unconditionally; the wait_buffer cannot stall:
//  - Store: merge into the line copy at offset = address[BLOCK_ID_START-1:0].
//    00110 SW writes 4 bytes at word (offset[1:0] ignored); 00111 SH writes 2 bytes at offset[1];
//    01000 SB writes 1 byte at offset[1:0].
//  - Load: read the line copy including stores merged in earlier cycles; push {data,dest,ticket}.
//    00001 LW; 00010 LH (sign-ext) / 00011 LHU (zero-ext); 00100 LB (sign) / 00101 LBU (zero).
//  - Any other microop: entry dropped, no effect.
//  - wb_search_found_multi=0 marks the last entry: go to WRITE next cycle.
// WRITE: line_wr_valid=1, data/address held stable until line_wr_ready; then go to IDLE.
//  line_wr_valid may already be high with ready high on the same edge.
// Load FIFO: WB_DEPTH-entry circular buffer with wrapping pointers and a count.
//  - Push in WALK; pop on ld_valid&&ld_ready. Simultaneous push and pop keeps count unchanged.
//  - ld_valid = !empty, registered; earliest ld_valid is the cycle after the push.
//  - FIFO drains concurrently with WRITE and following IDLE; the next fill waits for empty.
// Overflow cannot occur by construction; an overflow is a design bug, flagged in simulation by assertion.
// Widths: shifts and byte-lane selects use offset bits only; address upper bits ignored when merging.
// Reset mid-operation drops the line and FIFO contents. The wait_buffer must be reset in the same cycle.
// TESTING
// No match: fill 0x1000 with line = bytes 0..31 -> no invalidate; line_wr at 0x1000 unchanged; IDLE after ready.
// One LW at 0x1004 -> ld_data=0x07060504 with its dest/ticket; line unchanged; ld_valid 1 cycle after WALK.
// SW 0x1008=0xDEADBEEF, then LB 0x100B, then LHU 0x100A -> ld 0xFFFFFFDE then 0x0000DEAD;
//   written line word2=0xDEADBEEF.
// 8 matching loads, ld_ready=0 -> FIFO full; fill_ready=0 for the next fill until all 8 popped in order.
// line_wr_ready low 5 cycles -> valid/data stable throughout; single write accepted; entries invalidated exactly once.
// Reset asserted in WALK -> next cycle IDLE, ld_valid=0, line_wr_valid=0, fill_ready=1.

Source files
------------

// File: rtl/wait_buffer_replay_ctrl.sv
// Replays wait_buffer entries parked on a refilled miss block: merges stores into a local
// line copy, queues load results for writeback, then writes the merged line to the cache.
module wait_buffer_replay_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned BLOCK_ID_START = 5,
  parameter int unsigned R_WIDTH        = 6,
  parameter int unsigned MICROOP        = 5,
  parameter int unsigned ROB_TICKET     = 3,
  parameter int unsigned WB_DEPTH       = 8,
  localparam int unsigned LINE_BITS     = 8 << BLOCK_ID_START
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [ADDR_BITS-1:0]  fill_address,
  input  logic [LINE_BITS-1:0]  fill_line,
  output logic                  wb_search_invalidate,
  output logic [ADDR_BITS-1:0]  wb_search_address,
  input  logic                  wb_in_walk_mode,
  input  logic                  wb_search_found_one,
  input  logic                  wb_search_found_multi,
  input  logic                  wb_search_is_store,
  input  logic [ADDR_BITS-1:0]  wb_search_address_o,
  input  logic [DATA_WIDTH-1:0] wb_search_data,
  input  logic [MICROOP-1:0]    wb_search_microop,
  input  logic [R_WIDTH-1:0]    wb_search_dest,
  input  logic [ROB_TICKET-1:0] wb_search_ticket,
  output logic                  line_wr_valid,
  input  logic                  line_wr_ready,
  output logic [ADDR_BITS-1:0]  line_wr_address,
  output logic [LINE_BITS-1:0]  line_wr_data,
  output logic                  ld_valid,
  input  logic                  ld_ready,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [R_WIDTH-1:0]    ld_dest,
  output logic [ROB_TICKET-1:0] ld_ticket,
  output logic                  busy
);

  localparam int unsigned OffW   = BLOCK_ID_START;
  localparam int unsigned BlockW = ADDR_BITS - BLOCK_ID_START;
  localparam int unsigned PtrW   = $clog2(WB_DEPTH);
  localparam int unsigned CntW   = $clog2(WB_DEPTH + 1);

  localparam logic [MICROOP-1:0] UopLw  = MICROOP'(1);
  localparam logic [MICROOP-1:0] UopLh  = MICROOP'(2);
  localparam logic [MICROOP-1:0] UopLhu = MICROOP'(3);
  localparam logic [MICROOP-1:0] UopLb  = MICROOP'(4);
  localparam logic [MICROOP-1:0] UopLbu = MICROOP'(5);
  localparam logic [MICROOP-1:0] UopSw  = MICROOP'(6);
  localparam logic [MICROOP-1:0] UopSh  = MICROOP'(7);
  localparam logic [MICROOP-1:0] UopSb  = MICROOP'(8);

  typedef enum logic [1:0] {StIdle, StKick, StWalk, StWrite} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [R_WIDTH-1:0]    dest;
    logic [ROB_TICKET-1:0] ticket;
  } ld_entry_t;

  state_e                state_q, state_d;
  logic [BlockW-1:0]     block_q, block_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  ld_entry_t             mem_q [WB_DEPTH];
  ld_entry_t             mem_d [WB_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic                  push, pop;
  ld_entry_t             push_entry;
  logic [OffW-1:0]       off;
  logic [OffW-3:0]       word_idx;
  logic [OffW-2:0]       half_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [15:0]           rd_half;
  logic [7:0]            rd_byte;
  logic                  unused_addr_bits;

  // Only the offset bits of the entry address select lanes; the block is implied by the walk.
  assign off      = wb_search_address_o[OffW-1:0];
  assign word_idx = off[OffW-1:2];
  assign half_idx = off[OffW-1:1];
  assign rd_word  = line_q[{word_idx, 5'd0} +: 32];
  assign rd_half  = line_q[{half_idx, 4'd0} +: 16];
  assign rd_byte  = line_q[{off, 3'd0} +: 8];
  assign unused_addr_bits = ^{wb_search_address_o[ADDR_BITS-1:OffW], fill_address[OffW-1:0]};

  assign fill_ready        = (state_q == StIdle) && (count_q == '0);
  assign busy              = (state_q != StIdle);
  assign wb_search_address = {block_q, {OffW{1'b0}}};
  assign line_wr_valid     = (state_q == StWrite);
  assign line_wr_address   = line_wr_valid ? {block_q, {OffW{1'b0}}} : '0;
  assign line_wr_data      = line_wr_valid ? line_q : '0;
  assign ld_valid          = (count_q != '0);
  assign pop               = ld_valid && ld_ready;
  assign ld_data           = ld_valid ? mem_q[rd_ptr_q].data : '0;
  assign ld_dest           = ld_valid ? mem_q[rd_ptr_q].dest : '0;
  assign ld_ticket         = ld_valid ? mem_q[rd_ptr_q].ticket : '0;

  // Control FSM: capture fill, kick the search port, walk entries merging/extracting, write line.
  always_comb begin
    state_d              = state_q;
    block_d              = block_q;
    line_d               = line_q;
    wb_search_invalidate = 1'b0;
    push                 = 1'b0;
    push_entry           = '0;
    unique case (state_q)
      StIdle: begin
        if (fill_valid && fill_ready) begin
          block_d = fill_address[ADDR_BITS-1:OffW];
          line_d  = fill_line;
          state_d = StKick;
        end
      end
      StKick: begin
        if (!wb_in_walk_mode) begin
          if (wb_search_found_one) begin
            wb_search_invalidate = 1'b1;
            state_d              = StWalk;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWalk: begin
        push_entry.dest   = wb_search_dest;
        push_entry.ticket = wb_search_ticket;
        if (wb_search_is_store) begin
          case (wb_search_microop)
            UopSw:   line_d[{word_idx, 5'd0} +: 32] = wb_search_data;
            UopSh:   line_d[{half_idx, 4'd0} +: 16] = wb_search_data[15:0];
            UopSb:   line_d[{off, 3'd0} +: 8]       = wb_search_data[7:0];
            default: ;
          endcase
        end else begin
          push = 1'b1;
          case (wb_search_microop)
            UopLw:   push_entry.data = rd_word;
            UopLh:   push_entry.data = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            UopLhu:  push_entry.data = {{(DATA_WIDTH-16){1'b0}}, rd_half};
            UopLb:   push_entry.data = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            UopLbu:  push_entry.data = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
            default: push = 1'b0;
          endcase
        end
        if (!wb_search_found_multi) state_d = StWrite;
      end
      StWrite: begin
        if (line_wr_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load-result FIFO bookkeeping: circular buffer with explicit wrap and an occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PtrW'(WB_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(WB_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  // State registers with synchronous reset; reset drops the line copy and queued results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      block_q  <= '0;
      line_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      line_q   <= line_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // fill_ready gating guarantees room for every walked entry, so a full push is a bug.
  assert property (@(posedge clk) disable iff (rst)
                   !(push && !pop && (count_q == CntW'(WB_DEPTH))));

endmodule

// File: tb/tb_wait_buffer_replay_ctrl.sv
// Directed self-checking bench for wait_buffer_replay_ctrl.
module tb_wait_buffer_replay_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         fill_valid, fill_ready;
  logic [31:0]  fill_address;
  logic [255:0] fill_line;
  logic         wb_search_invalidate;
  logic [31:0]  wb_search_address;
  logic         wb_in_walk_mode, wb_search_found_one, wb_search_found_multi, wb_search_is_store;
  logic [31:0]  wb_search_address_o, wb_search_data;
  logic [4:0]   wb_search_microop;
  logic [5:0]   wb_search_dest;
  logic [2:0]   wb_search_ticket;
  logic         line_wr_valid, line_wr_ready;
  logic [31:0]  line_wr_address;
  logic [255:0] line_wr_data;
  logic         ld_valid, ld_ready;
  logic [31:0]  ld_data;
  logic [5:0]   ld_dest;
  logic [2:0]   ld_ticket;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [255:0] line0, line1, exp_line;

  wait_buffer_replay_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .fill_valid            (fill_valid),
    .fill_ready            (fill_ready),
    .fill_address          (fill_address),
    .fill_line             (fill_line),
    .wb_search_invalidate  (wb_search_invalidate),
    .wb_search_address     (wb_search_address),
    .wb_in_walk_mode       (wb_in_walk_mode),
    .wb_search_found_one   (wb_search_found_one),
    .wb_search_found_multi (wb_search_found_multi),
    .wb_search_is_store    (wb_search_is_store),
    .wb_search_address_o   (wb_search_address_o),
    .wb_search_data        (wb_search_data),
    .wb_search_microop     (wb_search_microop),
    .wb_search_dest        (wb_search_dest),
    .wb_search_ticket      (wb_search_ticket),
    .line_wr_valid         (line_wr_valid),
    .line_wr_ready         (line_wr_ready),
    .line_wr_address       (line_wr_address),
    .line_wr_data          (line_wr_data),
    .ld_valid              (ld_valid),
    .ld_ready              (ld_ready),
    .ld_data               (ld_data),
    .ld_dest               (ld_dest),
    .ld_ticket             (ld_ticket),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_in_walk_mode       = 1'b0;
    wb_search_found_one   = 1'b0;
    wb_search_found_multi = 1'b0;
    wb_search_is_store    = 1'b0;
    wb_search_address_o   = '0;
    wb_search_data        = '0;
    wb_search_microop     = '0;
    wb_search_dest        = '0;
    wb_search_ticket      = '0;
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [255:0] l);
    fill_valid   = 1'b1;
    fill_address = a;
    fill_line    = l;
    #1 check_eq("fill_ready_idle", fill_ready, 1'b1);
    tick();
    fill_valid = 1'b0;
    check_eq("busy_kick", busy, 1'b1);
    check_eq("search_addr", wb_search_address, a & 32'hFFFF_FFE0);
  endtask

  task automatic kick(input logic found);
    wb_in_walk_mode     = 1'b0;
    wb_search_found_one = found;
    #1 check_eq("kick_invalidate", wb_search_invalidate, found);
    tick();
    wb_search_found_one = 1'b0;
  endtask

  task automatic entry(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] u, input logic [5:0] de, input logic [2:0] tk,
                       input logic last);
    wb_search_found_one   = 1'b1;
    wb_search_found_multi = !last;
    wb_search_is_store    = st;
    wb_search_address_o   = a;
    wb_search_data        = d;
    wb_search_microop     = u;
    wb_search_dest        = de;
    wb_search_ticket      = tk;
    #1 check_eq("walk_no_invalidate", wb_search_invalidate, 1'b0);
    tick();
    clear_wb();
  endtask

  task automatic finish_write(input logic [31:0] a, input logic [255:0] l);
    check_eq("wr_valid", line_wr_valid, 1'b1);
    check_eq("wr_addr", line_wr_address, a);
    check_eq("wr_data", line_wr_data, l);
    line_wr_ready = 1'b1;
    tick();
    line_wr_ready = 1'b0;
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_wr_valid", line_wr_valid, 1'b0);
  endtask

  task automatic pop_check(input logic [31:0] d, input logic [5:0] de, input logic [2:0] tk);
    ld_ready = 1'b1;
    #1;
    check_eq("ld_valid", ld_valid, 1'b1);
    check_eq("ld_data", ld_data, d);
    check_eq("ld_dest", ld_dest, de);
    check_eq("ld_ticket", ld_ticket, tk);
    tick();
    ld_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      line0[i*8 +: 8] = 8'(i);
      line1[i*8 +: 8] = 8'(8'hA0 + i);
    end
    rst           = 1'b1;
    fill_valid    = 1'b0;
    fill_address  = '0;
    fill_line     = '0;
    line_wr_ready = 1'b0;
    ld_ready      = 1'b0;
    clear_wb();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_fill_ready", fill_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ld_valid", ld_valid, 1'b0);
    check_eq("rst_wr_valid", line_wr_valid, 1'b0);
    check_eq("rst_invalidate", wb_search_invalidate, 1'b0);
    check_eq("rst_ld_data", ld_data, 32'h0);
    check_eq("rst_wr_data", line_wr_data, 256'h0);

    // No matching entries: straight to write, line unchanged.
    do_fill(32'h0000_1000, line0);
    kick(1'b0);
    finish_write(32'h0000_1000, line0);
    check_eq("t1_fill_ready", fill_ready, 1'b1);

    // Single LW, with two cycles of the wait_buffer still walking a previous block.
    do_fill(32'h0000_1004, line0);
    wb_in_walk_mode     = 1'b1;
    wb_search_found_one = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("walk_mode_hold_inv", wb_search_invalidate, 1'b0);
      tick();
      check_eq("walk_mode_busy", busy, 1'b1);
    end
    kick(1'b1);
    check_eq("t2_ld_valid_early", ld_valid, 1'b0);
    entry(1'b0, 32'h0000_1004, 32'h0, 5'd1, 6'h2A, 3'd3, 1'b1);
    check_eq("t2_ld_valid", ld_valid, 1'b1);
    finish_write(32'h0000_1000, line0);
    check_eq("t2_fill_blocked", fill_ready, 1'b0);
    pop_check(32'h0706_0504, 6'h2A, 3'd3);
    check_eq("t2_ld_empty", ld_valid, 1'b0);
    check_eq("t2_fill_ready", fill_ready, 1'b1);

    // Mixed stores and loads merged oldest first; a stalled line write.
    do_fill(32'h0000_1000, line0);
    kick(1'b1);
    entry(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 5'd6, 6'd0, 3'd0, 1'b0);
    entry(1'b0, 32'h0000_100B, 32'h0, 5'd4, 6'd1, 3'd1, 1'b0);
    entry(1'b0, 32'h0000_100A, 32'h0, 5'd3, 6'd2, 3'd2, 1'b0);
    entry(1'b1, 32'h0000_1012, 32'h1234_CAFE, 5'd7, 6'd0, 3'd0, 1'b0);
    entry(1'b1, 32'h0000_1001, 32'h1234_5677, 5'd8, 6'd0, 3'd0, 1'b0);
    entry(1'b0, 32'h0000_1010, 32'h0, 5'd0, 6'd9, 3'd5, 1'b0);
    entry(1'b0, 32'h0000_1012, 32'h0, 5'd2, 6'd3, 3'd3, 1'b0);
    entry(1'b0, 32'h0000_1001, 32'h0, 5'd5, 6'd4, 3'd4, 1'b1);
    exp_line = line0;
    exp_line[64 +: 32]  = 32'hDEAD_BEEF;
    exp_line[144 +: 16] = 16'hCAFE;
    exp_line[8 +: 8]    = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", line_wr_valid, 1'b1);
      check_eq("stall_data", line_wr_data, exp_line);
      check_eq("stall_no_inv", wb_search_invalidate, 1'b0);
      tick();
    end
    finish_write(32'h0000_1000, exp_line);
    pop_check(32'hFFFF_FFDE, 6'd1, 3'd1);
    pop_check(32'h0000_DEAD, 6'd2, 3'd2);
    pop_check(32'hFFFF_CAFE, 6'd3, 3'd3);
    pop_check(32'h0000_0077, 6'd4, 3'd4);
    check_eq("t3_ld_empty", ld_valid, 1'b0);

    // Eight loads fill the FIFO; the next fill must wait until all are popped.
    do_fill(32'h0000_2000, line1);
    kick(1'b1);
    for (int i = 0; i < 8; i++) begin
      entry(1'b0, 32'h0000_2000 + 32'(4 * i), 32'h0, 5'd1, 6'(8 + i), 3'(i), i == 7);
    end
    finish_write(32'h0000_2000, line1);
    fill_valid   = 1'b1;
    fill_address = 32'h0000_3000;
    fill_line    = line0;
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("full_fill_ready", fill_ready, 1'b0);
      tick();
      check_eq("full_not_busy", busy, 1'b0);
    end
    fill_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_fill_ready", fill_ready, 1'b0);
      pop_check(line1[32*i +: 32], 6'(8 + i), 3'(i));
    end
    check_eq("t4_ld_empty", ld_valid, 1'b0);
    check_eq("t4_fill_ready", fill_ready, 1'b1);

    // Reset during WALK discards everything.
    do_fill(32'h0000_1000, line0);
    kick(1'b1);
    entry(1'b0, 32'h0000_1000, 32'h0, 5'd1, 6'd5, 3'd5, 1'b0);
    wb_search_found_multi = 1'b1;
    wb_search_microop     = 5'd1;
    rst                   = 1'b1;
    tick();
    rst = 1'b0;
    clear_wb();
    #1;
    check_eq("rst_walk_busy", busy, 1'b0);
    check_eq("rst_walk_ld_valid", ld_valid, 1'b0);
    check_eq("rst_walk_wr_valid", line_wr_valid, 1'b0);
    check_eq("rst_walk_fill_ready", fill_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
